// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues imem reads, buffers a word across IF/ID
// stalls, discards wrong-path returns after a redirect, and stops on the halt opcode.
//
// state  | meaning
// FETCH  | request outstanding at pc; a returned word goes straight to IF/ID
// HOLD   | word returned while IF/ID stalled; presented from the hold buffer
// DROP   | redirected during a miss; wait out the stale return, then jump
// HALTED | halt opcode accepted; fetch stopped until redirect or reset
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h00000000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic [31:0] instruction,
  output logic [31:0] imemaddr,
  output logic [31:0] next_imemaddr,
  output logic        enable_IF_ID,
  output logic        flush_IF_ID,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP, HALTED} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] hold_buf, hold_buf_n;
  logic [31:0] saved_target, saved_target_n;
  logic        ren, en, fl;
  logic [31:0] instr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= FETCH;
      pc           <= PC_RESET;
      hold_buf     <= 32'h0;
      saved_target <= 32'h0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      hold_buf     <= hold_buf_n;
      saved_target <= saved_target_n;
    end
  end

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    hold_buf_n     = hold_buf;
    saved_target_n = saved_target;
    ren            = 1'b0;
    en             = 1'b0;
    fl             = 1'b0;
    instr          = 32'h0;
    case (state)
      FETCH: begin
        ren   = 1'b1;
        instr = iload;
        if (redirect) begin
          fl = 1'b1;
          // A miss in flight must complete at its original address before jumping.
          if (ihit) begin
            pc_n = redirect_addr;
          end else begin
            saved_target_n = redirect_addr;
            state_n        = DROP;
          end
        end else if (ihit) begin
          if (!stall) begin
            en   = 1'b1;
            pc_n = pc + 32'd4;
            if (iload[31:26] == HALT_OP) state_n = HALTED;
          end else begin
            hold_buf_n = iload;
            state_n    = HOLD;
          end
        end
      end
      HOLD: begin
        instr = hold_buf;
        if (redirect) begin
          fl      = 1'b1;
          pc_n    = redirect_addr;
          state_n = FETCH;
        end else if (!stall) begin
          en      = 1'b1;
          pc_n    = pc + 32'd4;
          state_n = (hold_buf[31:26] == HALT_OP) ? HALTED : FETCH;
        end
      end
      DROP: begin
        ren   = 1'b1;
        instr = iload;
        if (redirect) begin
          fl             = 1'b1;
          saved_target_n = redirect_addr;
        end
        if (ihit) begin
          pc_n    = redirect ? redirect_addr : saved_target;
          state_n = FETCH;
        end
      end
      HALTED: begin
        if (redirect) begin
          fl      = 1'b1;
          pc_n    = redirect_addr;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // Outputs are forced quiet for the whole reset pulse, independent of the clock.
  assign iREN          = nRST & ren;
  assign enable_IF_ID  = nRST & en;
  assign flush_IF_ID   = nRST & fl;
  assign instruction   = nRST ? instr : 32'h0;
  assign iaddr         = pc;
  assign imemaddr      = pc;
  assign next_imemaddr = pc + 32'd4;
  assign halted        = (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes per-cycle expectations and accepted
// instructions into queues; monitors on the falling edge pop and compare.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] iload = 32'h0;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic [31:0] instruction;
  logic [31:0] imemaddr;
  logic [31:0] next_imemaddr;
  logic        enable_IF_ID;
  logic        flush_IF_ID;
  logic        halted;

  fetch_unit dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
    .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
    .instruction(instruction), .imemaddr(imemaddr), .next_imemaddr(next_imemaddr),
    .enable_IF_ID(enable_IF_ID), .flush_IF_ID(flush_IF_ID), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic        ren;
    logic [31:0] addr;
    logic        en;
    logic        fl;
    logic        hlt;
    logic [31:0] imem;
    logic        ci;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } acc_t;

  exp_t exp_q[$];
  acc_t acc_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("iREN", e.id, {31'h0, iREN}, {31'h0, e.ren});
      if (e.ren) chk("iaddr", e.id, iaddr, e.addr);
      chk("enable_IF_ID", e.id, {31'h0, enable_IF_ID}, {31'h0, e.en});
      chk("flush_IF_ID", e.id, {31'h0, flush_IF_ID}, {31'h0, e.fl});
      chk("halted", e.id, {31'h0, halted}, {31'h0, e.hlt});
      chk("imemaddr", e.id, imemaddr, e.imem);
      chk("next_imemaddr", e.id, next_imemaddr, e.imem + 32'd4);
      if (e.ci) chk("instruction", e.id, instruction, e.instr);
    end
  end

  always @(negedge CLK) begin
    if (enable_IF_ID) begin
      if (acc_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_unexpected: got addr %h, expected no accept", imemaddr);
      end else begin
        acc_t a;
        a = acc_q.pop_front();
        chk("accept_instr", -1, instruction, a.instr);
        chk("accept_addr", -1, imemaddr, a.addr);
      end
    end
  end

  task automatic step(
    input logic rst_b, input logic ih, input logic [31:0] ld, input logic st,
    input logic rd, input logic [31:0] ra,
    input logic e_ren, input logic [31:0] e_addr, input logic e_en, input logic e_fl,
    input logic e_hlt, input logic [31:0] e_imem, input logic e_ci, input logic [31:0] e_instr);
    exp_t e;
    @(posedge CLK);
    #1;
    nRST = rst_b; ihit = ih; iload = ld; stall = st; redirect = rd; redirect_addr = ra;
    step_id++;
    e.id = step_id; e.ren = e_ren; e.addr = e_addr; e.en = e_en; e.fl = e_fl;
    e.hlt = e_hlt; e.imem = e_imem; e.ci = e_ci; e.instr = e_instr;
    exp_q.push_back(e);
    if (e_en) acc_q.push_back('{instr: (e_ci ? e_instr : ld), addr: e_imem});
  endtask

  localparam logic [31:0] LW   = 32'h8C220004;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  localparam logic [31:0] NOP  = 32'h20000000;

  initial begin
    //   rst ih iload       st rd raddr   | ren iaddr    en fl hlt imem     ci instr
    step(0, 0, 32'h0,      0, 0, 32'h0,    0, 32'h0,    0, 0, 0, 32'h0,   1, 32'h0);
    // streaming fetch
    for (int i = 0; i < 4; i++)
      step(1, 1, NOP | i,  0, 0, 32'h0,    1, 32'(i*4), 1, 0, 0, 32'(i*4), 1, NOP | i);
    // stall three cycles at 0x10
    step(1, 1, LW,         1, 0, 32'h0,    1, 32'h10,   0, 0, 0, 32'h10,  0, 32'h0);
    step(1, 0, 32'h0,      1, 0, 32'h0,    0, 32'h0,    0, 0, 0, 32'h10,  1, LW);
    step(1, 0, 32'h0,      1, 0, 32'h0,    0, 32'h0,    0, 0, 0, 32'h10,  1, LW);
    step(1, 0, 32'h0,      0, 0, 32'h0,    0, 32'h0,    1, 0, 0, 32'h10,  1, LW);
    step(1, 1, NOP | 5,    0, 0, 32'h0,    1, 32'h14,   1, 0, 0, 32'h14,  0, 32'h0);
    step(1, 1, NOP | 6,    0, 0, 32'h0,    1, 32'h18,   1, 0, 0, 32'h18,  0, 32'h0);
    step(1, 1, NOP | 7,    0, 0, 32'h0,    1, 32'h1C,   1, 0, 0, 32'h1C,  0, 32'h0);
    // redirect during a miss at 0x20
    step(1, 0, 32'h0,      0, 1, 32'h100,  1, 32'h20,   0, 1, 0, 32'h20,  0, 32'h0);
    step(1, 0, 32'h0,      1, 0, 32'h0,    1, 32'h20,   0, 0, 0, 32'h20,  0, 32'h0);
    step(1, 1, NOP | 8,    0, 0, 32'h0,    1, 32'h20,   0, 0, 0, 32'h20,  0, 32'h0);
    step(1, 1, NOP | 9,    0, 0, 32'h0,    1, 32'h100,  1, 0, 0, 32'h100, 0, 32'h0);
    // redirect from HOLD with stall still high
    step(1, 1, NOP | 10,   1, 0, 32'h0,    1, 32'h104,  0, 0, 0, 32'h104, 0, 32'h0);
    step(1, 0, 32'h0,      1, 1, 32'h200,  0, 32'h0,    0, 1, 0, 32'h104, 1, NOP | 10);
    step(1, 1, NOP | 11,   0, 0, 32'h0,    1, 32'h200,  1, 0, 0, 32'h200, 0, 32'h0);
    // redirect on a hit, then halt at 0x30
    step(1, 1, NOP | 12,   1, 1, 32'h30,   1, 32'h204,  0, 1, 0, 32'h204, 0, 32'h0);
    step(1, 1, HALT,       0, 0, 32'h0,    1, 32'h30,   1, 0, 0, 32'h30,  0, 32'h0);
    step(1, 0, 32'h0,      1, 0, 32'h0,    0, 32'h0,    0, 0, 1, 32'h34,  0, 32'h0);
    step(1, 1, NOP,        0, 0, 32'h0,    0, 32'h0,    0, 0, 1, 32'h34,  0, 32'h0);
    step(1, 0, 32'h0,      0, 1, 32'h40,   0, 32'h0,    0, 1, 1, 32'h34,  0, 32'h0);
    step(1, 1, NOP | 13,   0, 0, 32'h0,    1, 32'h40,   1, 0, 0, 32'h40,  0, 32'h0);
    // halt opcode leaving HOLD
    step(1, 1, 32'hFC000000, 1, 0, 32'h0,  1, 32'h44,   0, 0, 0, 32'h44,  0, 32'h0);
    step(1, 0, 32'h0,      0, 0, 32'h0,    0, 32'h0,    1, 0, 0, 32'h44,  1, 32'hFC000000);
    step(1, 0, 32'h0,      0, 1, 32'h60,   0, 32'h0,    0, 1, 1, 32'h48,  0, 32'h0);
    // miss + redirect -> DROP, second redirect in DROP, then reset pulse
    step(1, 0, 32'h0,      0, 1, 32'h80,   1, 32'h60,   0, 1, 0, 32'h60,  0, 32'h0);
    step(1, 0, 32'h0,      0, 1, 32'h90,   1, 32'h60,   0, 1, 0, 32'h60,  0, 32'h0);
    step(0, 1, NOP,        1, 1, 32'h70,   0, 32'h0,    0, 0, 0, 32'h0,   1, 32'h0);
    step(1, 1, NOP | 14,   0, 0, 32'h0,    1, 32'h0,    1, 0, 0, 32'h0,   0, 32'h0);
    // DROP with redirect and hit in the same cycle: newest target wins
    step(1, 0, 32'h0,      0, 1, 32'h80,   1, 32'h4,    0, 1, 0, 32'h4,   0, 32'h0);
    step(1, 1, NOP,        0, 1, 32'h90,   1, 32'h4,    0, 1, 0, 32'h4,   0, 32'h0);
    step(1, 1, NOP | 15,   0, 0, 32'h0,    1, 32'h90,   1, 0, 0, 32'h90,  0, 32'h0);
    step(1, 0, 32'h0,      0, 0, 32'h0,    1, 32'h94,   0, 0, 0, 32'h94,  0, 32'h0);
    @(posedge CLK);
    #1;
    ihit = 1'b0;
    redirect = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("exp_queue_drained", 0, exp_q.size(), 0);
    chk("accept_queue_drained", 0, acc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1);
  end

endmodule
